mat16_stream_bridge: RTL and testbench

MAT16_STREAM_BRIDGE -- requirements
Module: mat16_stream_bridge

---
 rtl/mat16_pkg.sv | 7 +
 rtl/mat16_result_serializer.sv | 19 +
 rtl/mat16_stream_bridge.sv | 81 ++++++++
 tb/tb_mat16_stream_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mat16_pkg.sv
// mat16_pkg: shared sizes and sequencer state encoding for the matrix stream bridge
package mat16_pkg;
   localparam int WIDTH       = 16;
   localparam int MATRIX_SIZE = 16;
   localparam int NUM_ELEMS   = MATRIX_SIZE * MATRIX_SIZE;
   typedef enum logic [2:0] {LOAD_A, LOAD_B, CLR, RUN, DRAIN} state_t;
endpackage

// File: rtl/mat16_result_serializer.sv
// mat16_result_serializer: picks result element idx out of the flat multiplier word and flags the last one
module mat16_result_serializer
   import mat16_pkg::*;
#(
   parameter int W = WIDTH,
   parameter int N = NUM_ELEMS
) (
   input  logic [2*W*N-1:0] c_flat_i,
   input  logic [7:0]       idx_i,
   input  logic             active_i,
   output logic [2*W-1:0]   data_o,
   output logic             last_o
);
   // Element select is a plain mux; last only counts while the drain is active
   always_comb begin
      data_o = c_flat_i[idx_i*2*W +: 2*W];
      last_o = active_i && idx_i == 8'(N-1);
   end
endmodule

// File: rtl/mat16_stream_bridge.sv
// mat16_stream_bridge: streams A and B into a square multiplier, runs it, and streams C back out
module mat16_stream_bridge
   import mat16_pkg::*;
#(
   parameter int WIDTH       = mat16_pkg::WIDTH,
   parameter int MATRIX_SIZE = mat16_pkg::MATRIX_SIZE
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [WIDTH-1:0]                             in_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [2*WIDTH-1:0]                           out_data,
   output logic                                         out_last,
   output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]     mult_a_flat,
   output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]     mult_b_flat,
   input  logic [2*WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]   mult_c_flat,
   output logic                                         mult_rst,
   output logic                                         mult_start,
   input  logic                                         mult_done,
   output logic                                         busy
);
   localparam int ELEMS = MATRIX_SIZE * MATRIX_SIZE;
   state_t                   state_q;
   logic [7:0]               idx_q;
   logic [WIDTH*ELEMS-1:0]   a_q;
   logic [WIDTH*ELEMS-1:0]   b_q;
   logic                     last_idx;
   assign last_idx = idx_q == 8'(ELEMS-1);
   // Sequencer: fill A, fill B, clear the multiplier, run until done, then drain C
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         case (state_q)
            LOAD_A: if (in_valid) begin
               a_q[idx_q*WIDTH +: WIDTH] <= in_data;
               idx_q   <= last_idx ? '0 : idx_q + 8'd1;
               state_q <= last_idx ? LOAD_B : LOAD_A;
            end
            LOAD_B: if (in_valid) begin
               b_q[idx_q*WIDTH +: WIDTH] <= in_data;
               idx_q   <= last_idx ? '0 : idx_q + 8'd1;
               state_q <= last_idx ? CLR : LOAD_B;
            end
            CLR: state_q <= RUN;
            RUN: if (mult_done) begin
               idx_q   <= '0;
               state_q <= DRAIN;
            end
            DRAIN: if (out_ready) begin
               idx_q   <= last_idx ? '0 : idx_q + 8'd1;
               state_q <= last_idx ? LOAD_A : DRAIN;
            end
            default: state_q <= LOAD_A;
         endcase
      end
   end
   // Handshake and control strobes decode straight from the registered state
   always_comb begin
      in_ready    = !rst && (state_q == LOAD_A || state_q == LOAD_B);
      out_valid   = state_q == DRAIN;
      mult_start  = state_q == RUN;
      mult_rst    = rst || state_q == CLR;
      busy        = !(state_q == LOAD_A && idx_q == 8'd0);
      mult_a_flat = a_q;
      mult_b_flat = b_q;
   end
   mat16_result_serializer #(.W(WIDTH), .N(ELEMS)) u_ser (
      .c_flat_i (mult_c_flat),
      .idx_i    (idx_q),
      .active_i (out_valid),
      .data_o   (out_data),
      .last_o   (out_last)
   );
endmodule

// File: tb/tb_mat16_stream_bridge.sv
// tb_mat16_stream_bridge: directed jobs through the bridge with a behavioural multiplier and a result scoreboard
module tb_mat16_stream_bridge;
   localparam int W = 16;
   localparam int N = 256;
   localparam int K_ID = 0, K_ID2 = 1, K_RAMP = 2, K_ONES = 3;
   localparam int E_RAMP = 0, E_RAMP2 = 1, E_ONES = 2;

   typedef struct packed {
      logic [2*W-1:0] data;
      logic           last;
   } exp_t;

   logic             clk = 0;
   logic             rst = 1;
   logic             in_valid = 0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             out_valid;
   logic             out_ready = 1;
   logic [2*W-1:0]   out_data;
   logic             out_last;
   logic [W*N-1:0]   mult_a_flat, mult_b_flat;
   logic [2*W*N-1:0] mult_c_flat = '0;
   logic             mult_rst, mult_start, busy;
   logic             mult_done = 0;

   int   checks = 0, failures = 0;
   int   hs_cnt = 0, mrst_cnt = 0, mcnt = 0, burst = 0;
   bit   rand_ready = 0, rand_gaps = 0, stalled = 0;
   logic [2*W-1:0] held_data;
   logic           held_last;
   exp_t exp_q[$];

   mat16_stream_bridge #(.WIDTH(W), .MATRIX_SIZE(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .mult_a_flat(mult_a_flat), .mult_b_flat(mult_b_flat), .mult_c_flat(mult_c_flat),
      .mult_rst(mult_rst), .mult_start(mult_start), .mult_done(mult_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W*N-1:0] matmul(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
      logic [2*W*N-1:0] c;
      logic [31:0]      acc;
      c = '0;
      for (int r = 0; r < 16; r++)
         for (int col = 0; col < 16; col++) begin
            acc = '0;
            for (int k = 0; k < 16; k++)
               acc += 32'(a[(16*r+k)*W +: W]) * 32'(b[(16*k+col)*W +: W]);
            c[(16*r+col)*2*W +: 2*W] = acc;
         end
      return c;
   endfunction

   // Behavioural multiplier: cleared by mult_rst, finishes a few cycles into a start pass
   always @(posedge clk) begin
      if (mult_rst) begin
         mcnt        <= 0;
         mult_done   <= 0;
         mult_c_flat <= '0;
      end else if (mult_start && !mult_done) begin
         mcnt <= mcnt + 1;
         if (mcnt == 4) begin
            mult_c_flat <= matmul(mult_a_flat, mult_b_flat);
            mult_done   <= 1;
         end
      end else begin
         mult_done <= 0;
      end
   end

   function automatic logic [W-1:0] elem(input int kind, input int e);
      case (kind)
         K_ID:    return (e / 16 == e % 16) ? 16'd1 : 16'd0;
         K_ID2:   return (e / 16 == e % 16) ? 16'd2 : 16'd0;
         K_RAMP:  return 16'(e);
         default: return 16'hFFFF;
      endcase
   endfunction

   function automatic logic [2*W-1:0] expect_val(input int kind, input int e);
      case (kind)
         E_RAMP:  return 32'(e);
         E_RAMP2: return 32'(2 * e);
         default: return 32'hFFE00010;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      int t;
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
         in_valid = 0;
         repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1;
      in_data  = w;
      t = 0;
      while (!in_ready && t < 5000) begin @(posedge clk); #1; t++; end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         finish_run();
      end
      @(posedge clk); #1;
   endtask

   task automatic run_job(input int ak, input int bk, input int ek, input bit hold);
      for (int e = 0; e < N; e++) exp_q.push_back('{data: expect_val(ek, e), last: (e == N-1)});
      for (int e = 0; e < N; e++) begin
         send_word(elem(ak, e));
         if (e == 0) check("busy_after_first_word", busy, 1);
      end
      for (int e = 0; e < N; e++) send_word(elem(bk, e));
      in_data  = 16'hDEAD;
      in_valid = hold;
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((exp_q.size() != 0 || !in_ready) && t < budget) begin @(posedge clk); #1; t++; end
      check("drain_complete", exp_q.size() == 0 && in_ready, 1);
   endtask

   // out_ready driver: always ready, or random stall bursts when enabled
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!rand_ready) out_ready = 1;
         else if (burst > 0) begin out_ready = 0; burst--; end
         else if ($urandom_range(0, 5) == 0) begin out_ready = 0; burst = $urandom_range(0, 4); end
         else out_ready = 1;
      end
   end

   // Monitor: scoreboard pops on every output handshake, checks stall stability and drain flags
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (in_valid && in_ready) hs_cnt++;
         if (!rst && mult_rst) mrst_cnt++;
         if (out_valid) begin
            check("drain_in_ready", in_ready, 0);
            if (stalled) check("stall_hold", {out_data, out_last}, {held_data, held_last});
            if (out_ready) begin
               if (exp_q.size() == 0) check("unexpected_output", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("result", {out_data, out_last}, {e.data, e.last});
               end
            end
            stalled   = !out_ready;
            held_data = out_data;
            held_last = out_last;
         end else if (stalled) begin
            check("valid_dropped_in_stall", out_valid, 1);
            stalled = 0;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_mult_rst", mult_rst, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_mult_start", mult_start, 0);
      check("rst_a_clear", |mult_a_flat, 0);
      check("rst_b_clear", |mult_b_flat, 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_mult_rst", mult_rst, 0);
      @(posedge clk); #1;

      run_job(K_ID, K_RAMP, E_RAMP, 0);
      check("a_slot0", mult_a_flat[0 +: W], 1);
      check("a_slot1", mult_a_flat[W +: W], 0);
      check("a_slot17", mult_a_flat[17*W +: W], 1);
      check("b_slot255", mult_b_flat[255*W +: W], 255);
      run_job(K_ONES, K_ONES, E_ONES, 0);
      rand_gaps  = 1;
      rand_ready = 1;
      run_job(K_ID, K_RAMP, E_RAMP, 0);
      run_job(K_ID2, K_RAMP, E_RAMP2, 0);
      rand_gaps = 0;
      wait_idle(5000);

      for (int e = 0; e < N; e++) send_word(elem(K_ID, e));
      for (int e = 0; e < 100; e++) send_word(elem(K_RAMP, e));
      in_valid = 0;
      rst = 1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_mult_rst", mult_rst, 1);
      check("midrst_out_valid", out_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      check("postrst_in_ready", in_ready, 1);
      check("postrst_busy", busy, 0);
      @(posedge clk); #1;

      run_job(K_ID2, K_RAMP, E_RAMP2, 0);
      run_job(K_ID, K_RAMP, E_RAMP, 1);
      repeat (100) begin @(posedge clk); #1; end
      run_job(K_ID2, K_RAMP, E_RAMP2, 0);
      wait_idle(8000);

      check("mult_rst_pulses", mrst_cnt, 7);
      check("words_consumed", hs_cnt, 7*2*N + N + 100);
      finish_run();
   end
endmodule
